uart_rx_fifo: RTL and testbench

- Receive holding FIFO that sits directly downstream of the UART receive state machine.
- Captures each received character word (RD, strobed by WE_RHR) and buffers it for the host register interface.
- Provides empty, full, half-full and count status, a sticky overrun flag, and a receive-timeout flag for partially filled FIFOs.

---
 rtl/uart_rx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive holding FIFO between the UART receive state machine and the host interface.
// First-word-fall-through storage with registered status, sticky overrun and idle timeout.
module uart_rx_fifo #(
    parameter int unsigned Depth_Log2 = 4,
    parameter int unsigned TO_Len     = 640
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  CE_16x,
    input  logic                  Clr,
    input  logic                  WE_RHR,
    input  logic [9:0]            RD,
    input  logic                  RE,
    input  logic                  Clr_OE,
    output logic [9:0]            DO,
    output logic                  RF_EF,
    output logic                  RF_FF,
    output logic                  RF_HF,
    output logic [Depth_Log2:0]   RF_Cnt,
    output logic                  OE,
    output logic                  RTO
);

    localparam int unsigned DEPTH = 1 << Depth_Log2;
    localparam int unsigned PW    = Depth_Log2;
    localparam int unsigned CW    = Depth_Log2 + 1;
    localparam int unsigned TW    = $clog2(TO_Len + 1);

    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt_nxt;
    logic [TW-1:0] to_cnt;

    logic wr_ok;
    logic rd_ok;
    logic overrun;
    logic to_clr;

    // A read frees the slot the same-cycle write uses, so full+RE still accepts the write.
    assign wr_ok   = WE_RHR && !Clr && (!RF_FF || RE);
    assign rd_ok   = RE && !Clr && !RF_EF;
    assign overrun = WE_RHR && !Clr && RF_FF && !RE;
    assign to_clr  = Clr || wr_ok || rd_ok || RF_EF;

    assign DO = mem[rp];

    always_comb begin
        cnt_nxt = RF_Cnt;
        if (Clr) begin
            cnt_nxt = '0;
        end else if (wr_ok && !rd_ok) begin
            cnt_nxt = RF_Cnt + CW'(1);
        end else if (!wr_ok && rd_ok) begin
            cnt_nxt = RF_Cnt - CW'(1);
        end
    end

    // Storage array carries no reset; a reset-cycle write is discarded.
    always_ff @(posedge Clk) begin
        if (Rst && wr_ok) begin
            mem[wp] <= RD;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wp     <= '0;
            rp     <= '0;
            RF_Cnt <= '0;
            RF_EF  <= 1'b1;
            RF_FF  <= 1'b0;
            RF_HF  <= 1'b0;
        end else begin
            if (Clr) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (wr_ok) begin
                    wp <= wp + PW'(1);
                end
                if (rd_ok) begin
                    rp <= rp + PW'(1);
                end
            end
            RF_Cnt <= cnt_nxt;
            RF_EF  <= (cnt_nxt == '0);
            RF_FF  <= (cnt_nxt == CW'(DEPTH));
            RF_HF  <= cnt_nxt[Depth_Log2] | cnt_nxt[Depth_Log2-1];
        end
    end

    // Sticky overrun; a new drop wins over a same-cycle Clr_OE.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            OE <= 1'b0;
        end else if (Clr) begin
            OE <= 1'b0;
        end else if (overrun) begin
            OE <= 1'b1;
        end else if (Clr_OE) begin
            OE <= 1'b0;
        end
    end

    // Idle timer saturates at TO_Len; dropped writes do not count as activity.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            to_cnt <= '0;
            RTO    <= 1'b0;
        end else if (to_clr) begin
            to_cnt <= '0;
            RTO    <= 1'b0;
        end else if (CE_16x && (to_cnt != TW'(TO_Len))) begin
            to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TW'(TO_Len - 1)) begin
                RTO <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: fill/wrap, overrun, flush, timeout and reset.
module tb_uart_rx_fifo;

    logic       Clk;
    logic       Rst;
    logic       CE_16x;
    logic       Clr;
    logic       WE_RHR;
    logic [9:0] RD;
    logic       RE;
    logic       Clr_OE;
    logic [9:0] DO;
    logic       RF_EF;
    logic       RF_FF;
    logic       RF_HF;
    logic [4:0] RF_Cnt;
    logic       OE;
    logic       RTO;

    int n_assert = 0;
    int n_fail   = 0;

    uart_rx_fifo #(.Depth_Log2(4), .TO_Len(640)) dut (
        .Clk(Clk), .Rst(Rst), .CE_16x(CE_16x), .Clr(Clr), .WE_RHR(WE_RHR),
        .RD(RD), .RE(RE), .Clr_OE(Clr_OE), .DO(DO), .RF_EF(RF_EF),
        .RF_FF(RF_FF), .RF_HF(RF_HF), .RF_Cnt(RF_Cnt), .OE(OE), .RTO(RTO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] d);
        WE_RHR = 1'b1;
        RD     = d;
        cyc();
        WE_RHR = 1'b0;
    endtask

    task automatic rdp();
        RE = 1'b1;
        cyc();
        RE = 1'b0;
    endtask

    task automatic flush();
        Clr = 1'b1;
        cyc();
        Clr = 1'b0;
    endtask

    logic       seen;
    logic [9:0] exp_q [$];

    initial begin
        Rst = 1'b0; CE_16x = 1'b0; Clr = 1'b0; WE_RHR = 1'b0;
        RD = '0; RE = 1'b0; Clr_OE = 1'b0;

        // 1. Reset and single word
        repeat (3) cyc();
        Rst = 1'b1;
        check("rst_ef", 32'(RF_EF), 1);
        check("rst_cnt", 32'(RF_Cnt), 0);
        check("rst_ff", 32'(RF_FF), 0);
        check("rst_hf", 32'(RF_HF), 0);
        check("rst_oe", 32'(OE), 0);
        check("rst_rto", 32'(RTO), 0);
        wr(10'h077);
        check("w1_ef", 32'(RF_EF), 0);
        check("w1_cnt", 32'(RF_Cnt), 1);
        check("w1_do", 32'(DO), 32'h077);
        rdp();
        check("r1_ef", 32'(RF_EF), 1);
        check("r1_cnt", 32'(RF_Cnt), 0);

        // 2. Fill and wrap
        for (int i = 0; i < 16; i++) begin
            wr(10'(i));
            if (i == 6) check("hf_at7", 32'(RF_HF), 0);
            if (i == 7) check("hf_at8", 32'(RF_HF), 1);
            if (i == 14) check("ff_at15", 32'(RF_FF), 0);
        end
        check("fill_ff", 32'(RF_FF), 1);
        check("fill_cnt", 32'(RF_Cnt), 16);
        for (int i = 0; i < 4; i++) begin
            check("head", 32'(DO), 32'(i));
            rdp();
        end
        check("after4_cnt", 32'(RF_Cnt), 12);
        for (int i = 0; i < 4; i++) wr(10'h3A5 + 10'(i));
        check("refill_ff", 32'(RF_FF), 1);

        // 3. Overrun
        wr(10'h155);
        check("ovr_oe", 32'(OE), 1);
        check("ovr_cnt", 32'(RF_Cnt), 16);
        check("ovr_do", 32'(DO), 32'h004);
        RE = 1'b1;
        wr(10'h1C2);
        RE = 1'b0;
        check("fullwr_oe", 32'(OE), 1);
        check("fullwr_cnt", 32'(RF_Cnt), 16);
        check("fullwr_do", 32'(DO), 32'h005);
        Clr_OE = 1'b1; cyc(); Clr_OE = 1'b0;
        check("clroe", 32'(OE), 0);
        for (int i = 5; i < 16; i++) exp_q.push_back(10'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(10'h3A5 + 10'(i));
        exp_q.push_back(10'h1C2);
        while (exp_q.size() > 0) begin
            check("drain", 32'(DO), 32'(exp_q.pop_front()));
            rdp();
        end
        check("drain_ef", 32'(RF_EF), 1);
        rdp();
        check("re_empty_cnt", 32'(RF_Cnt), 0);
        check("re_empty_ef", 32'(RF_EF), 1);

        // 4. Simultaneous edge cases
        RE = 1'b1;
        wr(10'h2C3);
        RE = 1'b0;
        check("emp_wrre_cnt", 32'(RF_Cnt), 1);
        check("emp_wrre_do", 32'(DO), 32'h2C3);
        wr(10'h001);
        wr(10'h002);
        check("three_cnt", 32'(RF_Cnt), 3);
        Clr = 1'b1;
        wr(10'h111);
        Clr = 1'b0;
        check("clrwr_cnt", 32'(RF_Cnt), 0);
        check("clrwr_ef", 32'(RF_EF), 1);
        wr(10'h222);
        check("postclr_do", 32'(DO), 32'h222);
        flush();
        for (int i = 0; i < 16; i++) wr(10'h100 + 10'(i));
        Clr_OE = 1'b1;
        wr(10'h333);
        Clr_OE = 1'b0;
        check("clroe_vs_ovr", 32'(OE), 1);
        flush();
        check("clr_oe", 32'(OE), 0);
        check("clr_cnt", 32'(RF_Cnt), 0);

        // 5. Timeout
        CE_16x = 1'b1;
        wr(10'h1AB);
        repeat (639) cyc();
        check("to_639", 32'(RTO), 0);
        cyc();
        check("to_640", 32'(RTO), 1);
        wr(10'h1AC);
        check("to_wr_clr", 32'(RTO), 0);
        repeat (639) cyc();
        check("to2_639", 32'(RTO), 0);
        cyc();
        check("to2_640", 32'(RTO), 1);
        rdp();
        check("to_rd_clr", 32'(RTO), 0);
        rdp();
        check("to_empty", 32'(RF_EF), 1);
        seen = 1'b0;
        repeat (2000) begin
            cyc();
            if (RTO) seen = 1'b1;
        end
        check("to_never_empty", 32'(seen), 0);

        // 6. Reset mid-operation
        for (int i = 0; i < 16; i++) wr(10'h050 + 10'(i));
        wr(10'h3FF);
        for (int i = 0; i < 11; i++) rdp();
        repeat (640) cyc();
        check("pre_rst_cnt", 32'(RF_Cnt), 5);
        check("pre_rst_oe", 32'(OE), 1);
        check("pre_rst_rto", 32'(RTO), 1);
        Rst = 1'b0;
        cyc();
        Rst = 1'b1;
        check("mid_rst_ef", 32'(RF_EF), 1);
        check("mid_rst_cnt", 32'(RF_Cnt), 0);
        check("mid_rst_ff", 32'(RF_FF), 0);
        check("mid_rst_hf", 32'(RF_HF), 0);
        check("mid_rst_oe", 32'(OE), 0);
        check("mid_rst_rto", 32'(RTO), 0);
        wr(10'h0AA);
        check("post_rst_do", 32'(DO), 32'h0AA);
        check("post_rst_cnt", 32'(RF_Cnt), 1);
        rdp();
        check("post_rst_ef", 32'(RF_EF), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
